ycbcr_to_rgb: RTL and testbench

//  Inverse of the rgb_to_y luma path. Converts full-range BT.601 (JPEG) YCbCr pixels back to 8-bit RGB.

---
 rtl/ycbcr_to_rgb.sv | 247 ++++++++++++++++++++++++
 tb/tb_ycbcr_to_rgb.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ycbcr_to_rgb.sv
`default_nettype none
// ============================================================================
// Module   : ycbcr_to_rgb
// Purpose  : Full-range BT.601 (JPEG) YCbCr to 8-bit RGB converter.
//            Three-stage fixed-point pipeline with valid/ready handshakes on
//            both sides and per-channel saturation to 0..255.
//
// Ports    : clk_in        - system clock, rising edge
//            rst_n_in      - asynchronous active-low reset
//            y_in          - luma, unsigned 0..255
//            cb_in/cr_in   - chroma, unsigned, offset 128
//            valid_in      - input beat present
//            ready_out     - block accepts a beat this cycle
//            red_out/green_out/blue_out - converted pixel
//            valid_out     - output beat present
//            ready_in      - downstream accepts the output beat
//            sat_count_out - clipped-beat counter  (YCBCR2RGB_SAT_CNT_EN only)
//            sat_clr_in    - synchronous counter clear (YCBCR2RGB_SAT_CNT_EN only)
//
// Build option:
//            YCBCR2RGB_SAT_CNT_EN - when defined, adds a saturating 16-bit
//            counter of output beats in which any channel was clipped.
//            The datapath is identical in both builds.
//
// Revision : 1.0 - initial release
// ============================================================================
module ycbcr_to_rgb #(
    // Coefficients below are scaled for 8 fraction bits; other values are
    // not supported.
    parameter int FRAC_BITS = 8
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [7:0]  y_in,
    input  logic [7:0]  cb_in,
    input  logic [7:0]  cr_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic [7:0]  red_out,
    output logic [7:0]  green_out,
    output logic [7:0]  blue_out,
    output logic        valid_out,
    input  logic        ready_in
`ifdef YCBCR2RGB_SAT_CNT_EN
    ,
    output logic [15:0] sat_count_out,
    input  logic        sat_clr_in
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic signed [8:0]  c_CENTER = 9'sd128;
    localparam logic signed [17:0] c_K_R    = 18'sd359;   // 1.402 * 256
    localparam logic signed [17:0] c_K_GB   = 18'sd88;    // 0.344 * 256
    localparam logic signed [17:0] c_K_GR   = 18'sd183;   // 0.714 * 256
    localparam logic signed [17:0] c_K_B    = 18'sd454;   // 1.772 * 256
    localparam logic signed [19:0] c_ROUND  = 20'sd1 <<< (FRAC_BITS - 1);

    // ------------------------------------------------------------------------
    // Clip a signed, already-shifted channel value into 0..255.
    // ------------------------------------------------------------------------
    function automatic logic [7:0] f_clip(input logic signed [19:0] v);
        logic [7:0] res;
        if (v < 20'sd0) begin
            res = 8'd0;
        end else if (v > 20'sd255) begin
            res = 8'hFF;
        end else begin
            res = v[7:0];
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // Global stall: the whole pipe moves together. It may advance whenever the
    // output register is empty or is being drained this cycle, so bubbles are
    // carried through rather than squeezed out.
    // ------------------------------------------------------------------------
    logic w_en;

    assign w_en      = ready_in | ~valid_out;
    assign ready_out = w_en;

    // ------------------------------------------------------------------------
    // Stage 1: register luma and remove the chroma offset.
    // ------------------------------------------------------------------------
    logic              r_s1_valid;
    logic [7:0]        r_s1_y;
    logic signed [8:0] r_s1_dcb;
    logic signed [8:0] r_s1_dcr;
    logic signed [8:0] w_dcb;
    logic signed [8:0] w_dcr;

    assign w_dcb = $signed({1'b0, cb_in}) - c_CENTER;
    assign w_dcr = $signed({1'b0, cr_in}) - c_CENTER;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_s1_valid <= 1'b0;
            r_s1_y     <= '0;
            r_s1_dcb   <= '0;
            r_s1_dcr   <= '0;
        end else if (w_en) begin
            r_s1_valid <= valid_in;
            r_s1_y     <= y_in;
            r_s1_dcb   <= w_dcb;
            r_s1_dcr   <= w_dcr;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: chroma products and the luma term scaled to the product grid.
    // Largest magnitude is 454*128 = 58112, which fits an 18-bit signed value.
    // ------------------------------------------------------------------------
    logic                r_s2_valid;
    logic [16:0]         r_s2_y;
    logic signed [17:0]  r_s2_pr;
    logic signed [17:0]  r_s2_pgb;
    logic signed [17:0]  r_s2_pgr;
    logic signed [17:0]  r_s2_pb;
    logic signed [17:0]  w_dcb_x;
    logic signed [17:0]  w_dcr_x;
    logic signed [17:0]  w_pr;
    logic signed [17:0]  w_pgb;
    logic signed [17:0]  w_pgr;
    logic signed [17:0]  w_pb;
    logic [16:0]         w_y_sh;

    assign w_dcb_x = 18'(r_s1_dcb);
    assign w_dcr_x = 18'(r_s1_dcr);
    assign w_pr    = c_K_R  * w_dcr_x;
    assign w_pgb   = c_K_GB * w_dcb_x;
    assign w_pgr   = c_K_GR * w_dcr_x;
    assign w_pb    = c_K_B  * w_dcb_x;
    assign w_y_sh  = 17'(r_s1_y) << FRAC_BITS;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_s2_valid <= 1'b0;
            r_s2_y     <= '0;
            r_s2_pr    <= '0;
            r_s2_pgb   <= '0;
            r_s2_pgr   <= '0;
            r_s2_pb    <= '0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            r_s2_y     <= w_y_sh;
            r_s2_pr    <= w_pr;
            r_s2_pgb   <= w_pgb;
            r_s2_pgr   <= w_pgr;
            r_s2_pb    <= w_pb;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 3: sum, round half-up, arithmetic shift (floor) and clip.
    // ------------------------------------------------------------------------
    logic signed [19:0] w_y20;
    logic signed [19:0] w_pr20;
    logic signed [19:0] w_pgb20;
    logic signed [19:0] w_pgr20;
    logic signed [19:0] w_pb20;
    logic signed [19:0] w_sum_r;
    logic signed [19:0] w_sum_g;
    logic signed [19:0] w_sum_b;
    logic signed [19:0] w_q_r;
    logic signed [19:0] w_q_g;
    logic signed [19:0] w_q_b;

    assign w_y20   = 20'(r_s2_y);
    assign w_pr20  = 20'(r_s2_pr);
    assign w_pgb20 = 20'(r_s2_pgb);
    assign w_pgr20 = 20'(r_s2_pgr);
    assign w_pb20  = 20'(r_s2_pb);

    assign w_sum_r = w_y20 + w_pr20 + c_ROUND;
    assign w_sum_g = w_y20 - w_pgb20 - w_pgr20 + c_ROUND;
    assign w_sum_b = w_y20 + w_pb20 + c_ROUND;

    assign w_q_r   = w_sum_r >>> FRAC_BITS;
    assign w_q_g   = w_sum_g >>> FRAC_BITS;
    assign w_q_b   = w_sum_b >>> FRAC_BITS;

    // Data registers load on every enabled cycle, bubble or not; consumers
    // only look at them while valid_out is high.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_out <= 1'b0;
            red_out   <= '0;
            green_out <= '0;
            blue_out  <= '0;
        end else if (w_en) begin
            valid_out <= r_s2_valid;
            red_out   <= f_clip(w_q_r);
            green_out <= f_clip(w_q_g);
            blue_out  <= f_clip(w_q_b);
        end
    end

    // ------------------------------------------------------------------------
    // Saturation event counter
    // ------------------------------------------------------------------------
`ifdef YCBCR2RGB_SAT_CNT_EN
    // A beat counts as clipped when any channel's pre-clip value fell outside
    // 0..255 and was forced onto a bound.
    function automatic logic f_out_of_range(input logic signed [19:0] v);
        return (v < 20'sd0) || (v > 20'sd255);
    endfunction

    logic        r_s3_clip;
    logic [15:0] r_sat_cnt;
    logic        w_clip;
    logic        w_out_xfer;

    assign w_clip     = f_out_of_range(w_q_r) | f_out_of_range(w_q_g) |
                        f_out_of_range(w_q_b);
    assign w_out_xfer = valid_out & ready_in;

    // Travels alongside the stage-3 data so it describes the beat on the output.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_s3_clip <= 1'b0;
        end else if (w_en) begin
            r_s3_clip <= w_clip;
        end
    end

    // Clear has priority over increment; the count sticks at all-ones.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_sat_cnt <= '0;
        end else if (sat_clr_in) begin
            r_sat_cnt <= '0;
        end else if (w_out_xfer && r_s3_clip && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign sat_count_out = r_sat_cnt;
`else
    // No saturation tracking in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_ycbcr_to_rgb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ycbcr_to_rgb
// Purpose  : Self-checking bench for ycbcr_to_rgb: vector table with exact
//            latency, back-pressure, async reset, randomized stream against
//            an arithmetic reference, and (YCBCR2RGB_SAT_CNT_EN) counter checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ycbcr_to_rgb;

    logic        clk;
    logic        rst_n;
    logic [7:0]  y_in, cb_in, cr_in;
    logic        valid_in;
    logic        ready_out;
    logic [7:0]  red_out, green_out, blue_out;
    logic        valid_out;
    logic        ready_in;
`ifdef YCBCR2RGB_SAT_CNT_EN
    logic [15:0] sat_count;
    logic        sat_clr;
`endif

    ycbcr_to_rgb #(.FRAC_BITS(8)) dut (
        .clk_in    (clk),
        .rst_n_in  (rst_n),
        .y_in      (y_in),
        .cb_in     (cb_in),
        .cr_in     (cr_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .red_out   (red_out),
        .green_out (green_out),
        .blue_out  (blue_out),
        .valid_out (valid_out),
`ifdef YCBCR2RGB_SAT_CNT_EN
        .ready_in      (ready_in),
        .sat_count_out (sat_count),
        .sat_clr_in    (sat_clr)
`else
        .ready_in  (ready_in)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: the conversion equations in plain integer arithmetic.
    // ------------------------------------------------------------------------
    function automatic int floor_div256(input int a);
        if (a >= 0) return a / 256;
        return -((-a + 255) / 256);
    endfunction

    function automatic int clamp(input int v);
        if (v < 0)   return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic logic [23:0] model(input int y, input int cb, input int cr);
        int dcb, dcr, r, g, b;
        dcb = cb - 128;
        dcr = cr - 128;
        r = clamp(floor_div256(256 * y + 359 * dcr + 128));
        g = clamp(floor_div256(256 * y - 88 * dcb - 183 * dcr + 128));
        b = clamp(floor_div256(256 * y + 454 * dcb + 128));
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    // ------------------------------------------------------------------------
    // Scoreboard: record accepted inputs, compare each output transfer in order.
    // Handshakes are sampled on the falling edge, where they are settled.
    // ------------------------------------------------------------------------
    logic [23:0] sb[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_out && ready_in) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_beat: got rgb %0h expected no beat",
                             {red_out, green_out, blue_out});
                end else begin
                    chk("stream_rgb", 32'({red_out, green_out, blue_out}), 32'(sb.pop_front()));
                end
            end
            if (valid_in && ready_out) sb.push_back(model(y_in, cb_in, cr_in));
        end
    end

    // Present one beat and hold it until accepted.
    task automatic send(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
        bit acc;
        int guard;
        guard = 0;
        y_in = y; cb_in = cb; cr_in = cr; valid_in = 1'b1;
        do begin
            @(negedge clk);
            acc = ready_out;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 1000);
        if (!acc) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got no accept expected accept within 1000 cycles");
        end
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [7:0] y, cb, cr;
        logic [7:0] r, g, b;
    } vec_t;

    vec_t vt[8];
    bit   drv_done;
    logic [23:0] snap;

    initial begin
        vt[0] = '{8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128};
        vt[1] = '{8'd255, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255};
        vt[2] = '{8'd0,   8'd128, 8'd128, 8'd0,   8'd0,   8'd0};
        vt[3] = '{8'd76,  8'd85,  8'd255, 8'd254, 8'd0,   8'd0};
        vt[4] = '{8'd0,   8'd0,   8'd128, 8'd0,   8'd44,  8'd0};
        vt[5] = '{8'd255, 8'd128, 8'd255, 8'd255, 8'd164, 8'd255};
        vt[6] = '{8'd0,   8'd255, 8'd0,   8'd0,   8'd48,  8'd225};
        vt[7] = '{8'd128, 8'd0,   8'd255, 8'd255, 8'd81,  8'd0};

        rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        y_in = '0; cb_in = '0; cr_in = '0;
`ifdef YCBCR2RGB_SAT_CNT_EN
        sat_clr = 1'b0;
`endif
        #1;
        chk("reset_valid_out", 32'(valid_out), 32'd0);
        chk("reset_rgb", 32'({red_out, green_out, blue_out}), 32'd0);
        chk("reset_ready_out", 32'(ready_out), 32'd1);
`ifdef YCBCR2RGB_SAT_CNT_EN
        chk("reset_sat_count", 32'(sat_count), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_ready_out", 32'(ready_out), 32'd1);
        idle(2);

        // ---- Vector table, back-to-back, exact 3-cycle latency -----------
        for (int c = 0; c < 8 + 3; c++) begin
            if (c < 8) begin
                y_in = vt[c].y; cb_in = vt[c].cb; cr_in = vt[c].cr; valid_in = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
            @(posedge clk);
            #1;
            if (c >= 2 && c - 2 < 8) begin
                chk("table_valid", 32'(valid_out), 32'd1);
                chk("table_rgb", 32'({red_out, green_out, blue_out}),
                    32'({vt[c-2].r, vt[c-2].g, vt[c-2].b}));
            end else begin
                chk("table_bubble", 32'(valid_out), 32'd0);
            end
        end
        idle(3);

        // ---- Back-pressure: 6 beats, ready_in low for 4 cycles ------------
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(8'(20 + 40 * i), 8'(200 - 30 * i), 8'(60 + 25 * i));
                valid_in = 1'b0;
            end
            begin
                ready_in = 1'b1;
                repeat (4) begin @(posedge clk); #1; end
                ready_in = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("stall_valid_out", 32'(valid_out), 32'd1);
                    chk("stall_ready_out", 32'(ready_out), 32'd0);
                    if (k == 0) snap = {red_out, green_out, blue_out};
                    else chk("stall_stable", 32'({red_out, green_out, blue_out}), 32'(snap));
                    @(posedge clk);
                    #1;
                end
                ready_in = 1'b1;
            end
        join
        idle(6);
        chk("stall_drain", 32'(sb.size()), 32'd0);

        // ---- Randomized stream with random back-pressure ------------------
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    idle($urandom_range(0, 2));
                    send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                         8'($urandom_range(0, 255)));
                end
                valid_in = 1'b0;
                drv_done = 1'b1;
            end
            begin
                int cyc;
                cyc = 0;
                while ((!drv_done || sb.size() != 0) && cyc < 20000) begin
                    ready_in = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                    cyc++;
                end
                ready_in = 1'b1;
            end
        join
        chk("random_drain", 32'(sb.size()), 32'd0);
        idle(2);

        // ---- Async reset with 3 beats in flight ---------------------------
        for (int k = 0; k < 3; k++) begin
            y_in = 8'd200; cb_in = 8'(100 + k); cr_in = 8'd90; valid_in = 1'b1;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        chk("pre_reset_valid", 32'(valid_out), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_valid", 32'(valid_out), 32'd0);
        chk("async_reset_rgb", 32'({red_out, green_out, blue_out}), 32'd0);
        chk("async_reset_ready", 32'(ready_out), 32'd1);
        sb.delete();
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk("no_stale_beat", 32'(valid_out), 32'd0);
        end

`ifdef YCBCR2RGB_SAT_CNT_EN
        // ---- Saturation counter ------------------------------------------
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        chk("sat_cleared", 32'(sat_count), 32'd0);
        send(8'd255, 8'd128, 8'd255);
        idle(5);
        chk("sat_first_clip", 32'(sat_count), 32'd1);
        send(8'd128, 8'd128, 8'd128);
        idle(5);
        chk("sat_no_clip", 32'(sat_count), 32'd1);

        y_in = 8'd255; cb_in = 8'd128; cr_in = 8'd255; valid_in = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        idle(6);
        chk("sat_hold_ffff", 32'(sat_count), 32'hFFFF);

        for (int k = 0; k < 3; k++) begin
            bit seen;
            seen = 1'b0;
            send(8'd255, 8'd128, 8'd255);
            valid_in = 1'b0;
            for (int t = 0; t < 10 && !seen; t++) begin
                @(negedge clk);
                if (valid_out && ready_in) seen = 1'b1;
            end
            // Pulses 0 and 2 clear on the transfer edge; pulse 1 lets it count.
            if (k != 1) sat_clr = 1'b1;
            @(posedge clk); #1;
            sat_clr = 1'b0;
            chk("sat_transfer_seen", 32'(seen), 32'd1);
            chk("sat_clr_vs_inc", 32'(sat_count), (k == 1) ? 32'd1 : 32'd0);
        end
        idle(3);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
